// File: rtl/alu_resultado_etapa.sv
// rtl/alu_resultado_etapa.sv - registered ALU result stage with NZCV flags and architectural flag register
//
// Captures the ALU result with carry/overflow, derives NZCV on capture and
// forwards the entry downstream through a valid/ready handshake. The
// architectural flag register flags_q is written only when an entry marked
// set_flags is consumed downstream.
//
// Optional macro ALU_RESULT_SKID_EN:
//   defined   - two-entry buffer (main + skid). in_ready comes from a register,
//               so there is no combinational path from out_ready to in_ready.
//   undefined - single register; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  upstream handshake
//   in_result       N-bit ALU result
//   in_carry        ALU carry-out
//   in_overflow     ALU overflow
//   in_set_flags    entry updates architectural flags when consumed
//   out_valid/ready downstream handshake
//   out_result      registered result
//   out_nzcv        flags of the registered result {N,Z,C,V}
//   out_set_flags   registered in_set_flags
//   flags_q         architectural NZCV register
module alu_resultado_etapa #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_result,
    input  logic         in_carry,
    input  logic         in_overflow,
    input  logic         in_set_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_nzcv,
    output logic         out_set_flags,
    output logic [3:0]   flags_q
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t       state_q;
    occ_t       state_d;
    logic       in_xfer;
    logic       out_xfer;
    logic       load_main;
    logic [3:0] nzcv_in;

    assign nzcv_in   = {in_result[N-1], (in_result == '0), in_carry, in_overflow};
    assign out_valid = (state_q != EMPTY);
    assign out_xfer  = out_valid && out_ready;
    assign in_xfer   = in_valid && in_ready;

`ifdef ALU_RESULT_SKID_EN
    logic         in_ready_q;
    logic         load_skid;
    logic         move_skid;
    logic [N-1:0] skid_result;
    logic [3:0]   skid_nzcv;
    logic         skid_set_flags;

    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
`ifdef ALU_RESULT_SKID_EN
        load_skid = 1'b0;
        move_skid = 1'b0;
`endif
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                // Simultaneous transfer: old entry leaves, new one reloads main.
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
`ifdef ALU_RESULT_SKID_EN
                end else if (in_xfer) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
`endif
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
`ifdef ALU_RESULT_SKID_EN
            TWO: begin
                // in_ready is low here, so only the drain path exists.
                if (out_xfer) begin
                    state_d   = ONE;
                    move_skid = 1'b1;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            out_result    <= '0;
            out_nzcv      <= 4'b0000;
            out_set_flags <= 1'b0;
            flags_q       <= 4'b0000;
`ifdef ALU_RESULT_SKID_EN
            in_ready_q     <= 1'b1;
            skid_result    <= '0;
            skid_nzcv      <= 4'b0000;
            skid_set_flags <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (load_main) begin
                out_result    <= in_result;
                out_nzcv      <= nzcv_in;
                out_set_flags <= in_set_flags;
`ifdef ALU_RESULT_SKID_EN
            end else if (move_skid) begin
                out_result    <= skid_result;
                out_nzcv      <= skid_nzcv;
                out_set_flags <= skid_set_flags;
`endif
            end
`ifdef ALU_RESULT_SKID_EN
            if (load_skid) begin
                skid_result    <= in_result;
                skid_nzcv      <= nzcv_in;
                skid_set_flags <= in_set_flags;
            end
            // Registered ready: accept whenever the next state leaves a free slot.
            in_ready_q <= (state_d != TWO);
`endif
            if (out_xfer && out_set_flags) begin
                flags_q <= out_nzcv;
            end
        end
    end

endmodule

// File: tb/tb_alu_resultado_etapa.sv
// tb/tb_alu_resultado_etapa.sv - self-checking bench for alu_resultado_etapa
module tb_alu_resultado_etapa;

    localparam int N = 8;
`ifdef ALU_RESULT_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_result = '0;
    logic         in_carry = 1'b0;
    logic         in_overflow = 1'b0;
    logic         in_set_flags = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_result;
    logic [3:0]   out_nzcv;
    logic         out_set_flags;
    logic [3:0]   flags_q;

    always #5 clk = ~clk;

    alu_resultado_etapa #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .in_carry(in_carry),
        .in_overflow(in_overflow),
        .in_set_flags(in_set_flags),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_nzcv(out_nzcv),
        .out_set_flags(out_set_flags),
        .flags_q(flags_q)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [N-1:0] r;
        logic [3:0]   f;
        logic         sf;
    } ent_t;

    function automatic ent_t mk(input logic [N-1:0] r, input logic c, input logic v, input logic s);
        ent_t e;
        int   val;
        val  = int'(r);
        e.r  = r;
        e.f  = {(val >= (1 << (N - 1))), (val == 0), c, v};
        e.sf = s;
        return e;
    endfunction

    // Reference model: queue of buffered entries plus architectural flags.
    ent_t         mq[$];
    logic [3:0]   mflags = 4'b0000;
    logic         was_rst = 1'b1;
    bit           mon_en = 1'b0;
    logic [N-1:0] seen[$];

    always @(negedge clk) begin
        logic ir_exp;
        ent_t e;
        if (mon_en) begin
            ir_exp = SKID ? (mq.size() < 2) : (mq.size() == 0 || out_ready);
            chk("out_valid", out_valid, mq.size() != 0);
            chk("in_ready", in_ready, ir_exp);
            chk("flags_q", flags_q, mflags);
            if (mq.size() != 0) begin
                chk("out_result", out_result, mq[0].r);
                chk("out_nzcv", out_nzcv, mq[0].f);
                chk("out_set_flags", out_set_flags, mq[0].sf);
            end
            if (was_rst) begin
                chk("rst_out_result", out_result, 0);
                chk("rst_out_nzcv", out_nzcv, 0);
                chk("rst_out_set_flags", out_set_flags, 0);
            end
            if (rst) begin
                mq.delete();
                mflags  = 4'b0000;
                was_rst = 1'b1;
            end else begin
                was_rst = 1'b0;
                if (mq.size() != 0 && out_ready) begin
                    e = mq.pop_front();
                    seen.push_back(e.r);
                    if (e.sf) mflags = e.f;
                end
                if (in_valid && ir_exp) mq.push_back(mk(in_result, in_carry, in_overflow, in_set_flags));
            end
        end
    end

    int acc = 0;
    int lowready = 0;

    task automatic cycle();
        @(negedge clk);
        if (in_valid && in_ready) acc++;
        if (!in_ready) lowready++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] r, input logic c, input logic o, input logic s);
        in_valid     = v;
        in_result    = r;
        in_carry     = c;
        in_overflow  = o;
        in_set_flags = s;
    endtask

    initial begin
        int a0;
        int k;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cycle();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_flags_q", flags_q, 0);

        // Zero result sets Z; flags_q follows one cycle after the transfer.
        out_ready = 1'b1;
        drive(1, 8'h00, 0, 0, 1);
        cycle();
        drive(0, 8'h00, 0, 0, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_result", out_result, 8'h00);
        chk("t1_out_nzcv", out_nzcv, 4'b0100);
        cycle();
        chk("t1_flags_q", flags_q, 4'b0100);

        // Non flag-setting entry leaves flags_q alone.
        drive(1, 8'h81, 1, 0, 0);
        cycle();
        drive(0, 8'h00, 0, 0, 0);
        chk("t2_out_nzcv", out_nzcv, 4'b1010);
        cycle();
        chk("t2_flags_q", flags_q, 4'b0100);

        // Stalled back-to-back sequence.
        seen.delete();
        out_ready = 1'b0;
        a0 = acc;
        for (int c = 0; c < 3; c++) begin
            drive(1, 8'(acc - a0 + 1), 0, 0, 0);
            cycle();
        end
        chk("t3_accepts_stalled", acc - a0, SKID ? 2 : 1);
        out_ready = 1'b1;
        k = 0;
        while ((acc - a0) < 3 && k < 10) begin
            drive(1, 8'(acc - a0 + 1), 0, 0, 0);
            cycle();
            k++;
        end
        drive(0, 8'h00, 0, 0, 0);
        cycle();
        cycle();
        chk("t3_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("t3_first", seen[0], 8'h01);
            chk("t3_second", seen[1], 8'h02);
            chk("t3_third", seen[2], 8'h03);
        end

        // Full throughput with out_ready held high.
        seen.delete();
        a0 = acc;
        lowready = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'(8'h10 + i), 1, 0, 1);
            cycle();
            if (i == 0) chk("t4_latency", out_valid, 1);
        end
        chk("t4_in_ready_low", lowready, 0);
        drive(0, 8'h00, 0, 0, 0);
        cycle();
        cycle();
        chk("t4_accepts", acc - a0, 10);
        chk("t4_outputs", seen.size(), 10);
        if (seen.size() == 10) chk("t4_last", seen[9], 8'h19);
        chk("t4_flags_q", flags_q, 4'b0010);

        // Reset mid-stall discards buffered entries.
        out_ready = 1'b0;
        drive(1, 8'hA1, 0, 1, 1);
        cycle();
        drive(1, 8'hA2, 0, 1, 1);
        cycle();
        drive(0, 8'h00, 0, 0, 0);
        chk("t5_held", out_valid, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_flags_q", flags_q, 0);
        chk("t5_in_ready", in_ready, 1);
        seen.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("t5_nothing_emitted", seen.size(), 0);

        // Output held stable under stall while inputs change.
        out_ready = 1'b0;
        drive(1, 8'h5A, 0, 0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), 1'($urandom));
            cycle();
            chk("t6_hold_result", out_result, 8'h5A);
            chk("t6_hold_nzcv", out_nzcv, 4'b0000);
        end
        drive(0, 8'h00, 0, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;
        drive(0, 8'h00, 0, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("final_empty", out_valid, 0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_resultado_etapa.md
# alu_resultado_etapa

Registered result stage directly downstream of the ALU logical/rotate datapath (circular-shift, AND/OR/XOR units). Captures the N-bit ALU result plus carry/overflow, computes NZCV flags, and forwards them to writeback through a valid/ready handshake. Holds the architectural flag register, updated only when a flag-setting result is consumed. Provides the first pipeline cut after the combinational ALU.

## Interface
- N, default 8, result width (≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_result  in  N  ALU result (e.g. rotator output z)
- in_carry  in  1  carry-out from ALU (rotate: last bit rotated out, i.e. result[N-1] when amount≠0)
- in_overflow  in  1  overflow from ALU (0 for logical ops)
- in_set_flags  in  1  result updates architectural flags
- out_valid  out  1  registered result valid
- out_ready  in  1  consumer accepts
- out_result  out  N  registered result
- out_nzcv  out  4  flags of this result {N,Z,C,V}
- out_set_flags  out  1  registered in_set_flags
- flags_q  out  4  architectural NZCV register

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Flag computation on capture: N=in_result[N-1]; Z=(in_result==0); C=in_carry; V=in_overflow.
- flags_q <= out_nzcv on an output transfer with out_set_flags=1; otherwise holds.
- Entries leave strictly in arrival order; none dropped or duplicated.
- out_result/out_nzcv/out_set_flags stable while out_valid && !out_ready.
- Reset (any cycle, including mid-stall): out_valid=0, out_result=0, out_nzcv=0, out_set_flags=0, flags_q=0, all buffered entries discarded; in_ready=1 in the cycle after reset deasserts.
- in_* ignored when in_valid=0; out_ready ignored when out_valid=0.

## Timing
- Latency: input transfer in cycle t → out_valid=1 in cycle t+1.
- flags_q reflects an output transfer at cycle t from cycle t+1.
- States (occupancy): EMPTY (0 entries), ONE (main reg full), TWO (main + skid full; only with ALU_RESULT_SKID_EN).
  - EMPTY: in xfer → ONE.
  - ONE: in xfer & out xfer → ONE (main reloaded); in xfer only → TWO (skid) / stays ONE-blocked (no skid, in_ready=0 so impossible); out xfer only → EMPTY.
  - TWO: out xfer → ONE (skid moves to main); in_ready=0.
- Simultaneous in/out transfer in ONE: old entry leaves, new entry occupies main next cycle; throughput 1/cycle.

## Configuration
- ALU_RESULT_SKID_EN defined: 2-entry skid buffer; in_ready is a register (=!TWO), no combinational path out_ready→in_ready; full throughput sustained under out_ready toggling.
- Undefined: single register; in_ready = !out_valid || out_ready (combinational); TWO state absent. Flag, ordering and reset behaviour identical.

## Test plan
- Reset then in_result=8'h00, carry=0, ovf=0, set_flags=1, out_ready=1 → next cycle out_result=8'h00, out_nzcv=4'b0100; following cycle flags_q=4'b0100.
- in_result=8'h81, carry=1, set_flags=0 → out_nzcv=4'b1010; flags_q unchanged after transfer.
- Back-to-back 8'h01,8'h02,8'h03 with out_ready=0 for 3 cycles then 1 → with skid: in_ready drops after 2 accepts, outputs 01,02,03 in order; without: in_ready drops after 1 accept, same order.
- out_ready=1 constant, in_valid=1 for 10 cycles with incrementing values → 10 consecutive output transfers, 1-cycle latency, in_ready never 0.
- Stall with 2 entries held, assert rst one cycle → out_valid=0, flags_q=0, old entries never emitted; in_ready=1 next cycle.
- Output held with out_ready=0 while in_result changes → out_result/out_nzcv unchanged until transfer.
